// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard. Keeps one countdown per architectural register for writes whose
// results are not yet forwardable, and stalls the ID instruction while any of its used sources is pending.
module reg_write_scoreboard #(
   parameter int REG_LOG = 5,
   parameter int LAT_W   = 6,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 issue_valid,
   input  logic [REG_LOG-1:0]   issue_rd,
   input  logic                 issue_we,
   input  logic [LAT_W-1:0]     issue_lat,
   input  logic [REG_LOG*3-1:0] rs_ID,
   input  logic [2:0]           rs_used,
   input  logic                 freeze,
   input  logic                 flush,
   output logic                 stall,
   output logic                 issue_accept,
   output logic [2**REG_LOG-1:0] pending_mask,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam int NREG = 2**REG_LOG;

   // r0 is hardwired zero, so it gets no counter at all
   logic [LAT_W-1:0] cnt     [1:NREG-1];
   logic [LAT_W-1:0] cnt_nxt [1:NREG-1];
   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_nxt;
   logic [REG_LOG-1:0] rs_k;

   always_comb begin
      busy = '0;
      for (int r = 1; r < NREG; r++) begin
         busy[r] = (cnt[r] != '0);
      end
   end

   // Checked against pre-update counters: rs==rd sees only the older writer
   always_comb begin
      stall = 1'b0;
      rs_k  = '0;
      for (int k = 0; k < 3; k++) begin
         rs_k  = rs_ID[k*REG_LOG +: REG_LOG];
         stall = stall | (rs_used[k] & (rs_k != '0) & busy[rs_k]);
      end
   end

   assign issue_accept = issue_valid & ~stall & ~freeze & ~flush;

   // A new write overrides the same-cycle decrement of its entry
   always_comb begin
      busy_nxt = '0;
      for (int r = 1; r < NREG; r++) begin
         if (freeze) begin
            cnt_nxt[r] = cnt[r];
         end else if (issue_accept && issue_we && (issue_rd == REG_LOG'(r))) begin
            cnt_nxt[r] = issue_lat;
         end else if (busy[r]) begin
            cnt_nxt[r] = cnt[r] - LAT_W'(1);
         end else begin
            cnt_nxt[r] = cnt[r];
         end
         busy_nxt[r] = (cnt_nxt[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int r = 1; r < NREG; r++) begin
            cnt[r] <= '0;
         end
         pending_mask <= '0;
         stall_cycles <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
         pending_mask <= busy_nxt;
         if (stall && !freeze && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard: load-use, long latency, freeze, WAW/r0, flush, mid-run reset.
module tb_reg_write_scoreboard;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_we;
   logic [5:0]  issue_lat;
   logic [14:0] rs_ID;
   logic [2:0]  rs_used;
   logic        freeze;
   logic        flush;
   logic        stall;
   logic        issue_accept;
   logic [31:0] pending_mask;
   logic [31:0] stall_cycles;

   int ncmp = 0;
   int nerr = 0;
   int n;

   always #5 clk = ~clk;

   reg_write_scoreboard dut (
      .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_we(issue_we), .issue_lat(issue_lat), .rs_ID(rs_ID), .rs_used(rs_used),
      .freeze(freeze), .flush(flush), .stall(stall), .issue_accept(issue_accept),
      .pending_mask(pending_mask), .stall_cycles(stall_cycles)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; outputs are sampled 3 units later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0; issue_lat = '0;
      rs_ID = '0; rs_used = '0; freeze = 1'b0; flush = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [5:0] lat);
      idle();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd; issue_lat = lat;
   endtask

   initial begin
      // reset with random inputs
      rstn = 1'b0;
      issue_valid = 1'($urandom); issue_rd = 5'($urandom); issue_we = 1'($urandom);
      issue_lat = 6'($urandom); rs_ID = 15'($urandom); rs_used = 3'($urandom);
      freeze = 1'($urandom); flush = 1'($urandom);
      repeat (2) @(posedge clk);
      #1;
      rs_used = 3'b111;
      settle();
      chk("reset_stall", stall, 1'b0);
      chk("reset_pending", pending_mask, 32'h0);
      chk("reset_stall_cycles", stall_cycles, 32'h0);
      idle();
      rstn = 1'b1;

      // load-use: rd=5 lat=1
      tick(); issue(5'd5, 6'd1); settle();
      chk("lu_accept", issue_accept, 1'b1);
      tick(); idle(); issue_valid = 1'b1; rs_ID = 15'd5; rs_used = 3'b001; settle();
      chk("lu_stall", stall, 1'b1);
      chk("lu_accept_blocked", issue_accept, 1'b0);
      chk("lu_pending5", pending_mask[5], 1'b1);
      tick(); settle();
      chk("lu_released", stall, 1'b0);
      chk("lu_accept_after", issue_accept, 1'b1);
      chk("lu_pending_clear", pending_mask, 32'h0);
      chk("lu_stall_cycles", stall_cycles, 32'd1);

      // divider: rd=7 lat=34, dependent on rs1
      tick(); issue(5'd7, 6'd34); settle();
      tick(); idle(); issue_valid = 1'b1; rs_ID = {5'd0, 5'd7, 5'd0}; rs_used = 3'b010; settle();
      chk("div_pending7", pending_mask[7], 1'b1);
      n = 0;
      while (stall && n < 100) begin
         n++;
         tick(); settle();
      end
      chk("div_stall_len", 64'(n), 64'd34);
      chk("div_pending7_clear", pending_mask[7], 1'b0);
      chk("div_stall_cycles", stall_cycles, 32'd35);

      // freeze mid-countdown: rd=3 lat=4
      tick(); issue(5'd3, 6'd4); settle();
      chk("frz_accept", issue_accept, 1'b1);
      tick(); idle(); issue_valid = 1'b1; rs_ID = 15'd3; rs_used = 3'b001; settle();
      chk("frz_stall_a", stall, 1'b1);
      tick(); settle();
      chk("frz_stall_b", stall, 1'b1);
      tick(); freeze = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("frz_hold_stall", stall, 1'b1);
         chk("frz_no_accept", issue_accept, 1'b0);
         chk("frz_pending3", pending_mask[3], 1'b1);
         chk("frz_sc_hold", stall_cycles, 32'd37);
         tick();
      end
      freeze = 1'b0; settle();
      chk("frz_sc_after", stall_cycles, 32'd37);
      n = 0;
      while (stall && n < 100) begin
         n++;
         tick(); settle();
      end
      chk("frz_remaining", 64'(n), 64'd2);
      chk("frz_sc_total", stall_cycles, 32'd39);

      // WAW and r0
      tick(); issue(5'd9, 6'd20); settle();
      tick(); issue(5'd9, 6'd0); settle();
      chk("waw_pending9_set", pending_mask[9], 1'b1);
      chk("waw_accept", issue_accept, 1'b1);
      tick(); issue(5'd0, 6'd30); settle();
      chk("waw_pending9_clr", pending_mask[9], 1'b0);
      chk("r0_accept", issue_accept, 1'b1);
      tick(); idle(); settle();
      chk("r0_no_entry", pending_mask, 32'h0);
      rs_ID = '0; rs_used = 3'b111; settle();
      chk("r0_no_stall", stall, 1'b0);
      tick(); issue(5'd12, 6'd5); settle();
      tick(); idle(); rs_ID = {5'd12, 5'd0, 5'd0}; rs_used = 3'b000; #1;
      chk("unused_no_stall", stall, 1'b0);
      rs_used = 3'b100; #1;
      chk("used_rs2_stall", stall, 1'b1);
      rs_used = 3'b000; settle();

      // flush blocks issue, existing entry keeps counting
      tick(); issue(5'd14, 6'd3); settle();
      tick(); issue(5'd20, 6'd10); flush = 1'b1; settle();
      chk("flush_no_accept", issue_accept, 1'b0);
      tick(); idle(); settle();
      chk("flush_no_entry", pending_mask[20], 1'b0);
      chk("flush_entry14_live", pending_mask[14], 1'b1);
      tick(); tick(); settle();
      chk("flush_entry14_done", pending_mask[14], 1'b0);
      chk("sc_untouched", stall_cycles, 32'd39);

      // reset mid-operation drops pending entries
      tick(); issue(5'd2, 6'd10); settle();
      tick(); idle(); rstn = 1'b0; settle();
      tick(); rstn = 1'b1; rs_ID = 15'd2; rs_used = 3'b001; settle();
      chk("midrst_pending", pending_mask, 32'h0);
      chk("midrst_stall", stall, 1'b0);
      chk("midrst_sc", stall_cycles, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
